// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring unsigned divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to finish zero-divisor requests in one cycle and raise div_by_zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             done_next;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
`ifdef DIV_ZERO_DETECT_EN
  logic             zero_reg, zero_next;
  logic             dz_reg, dz_next;
`endif

  // The partial remainder always stays below the divisor, so it is stored in WIDTH
  // bits; the extra carry bit only exists in the trial value used for the compare.
  always_comb begin
    state_next     = state;
    q_next         = q_reg;
    d_next         = d_reg;
    r_next         = r_reg;
    count_next     = count;
    quotient_next  = quotient;
    remainder_next = remainder;
    done_next      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    zero_next      = zero_reg;
    dz_next        = dz_reg;
`endif
    trial = {r_reg, q_reg[WIDTH-1]};
    diff  = trial[WIDTH-1:0] - d_reg;

    case (state)
      IDLE: begin
        if (start) begin
          q_next     = dividend;
          d_next     = divisor;
          r_next     = '0;
          count_next = CW'(WIDTH);
          state_next = RUN;
`ifdef DIV_ZERO_DETECT_EN
          zero_next  = 1'b0;
          // Preload the known answer and skip straight to the result cycle.
          if (divisor == '0) begin
            q_next     = '1;
            r_next     = dividend;
            count_next = '0;
            zero_next  = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        if (count != '0) begin
          if (trial >= {1'b0, d_reg}) begin
            r_next = diff;
            q_next = {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            r_next = trial[WIDTH-1:0];
            q_next = {q_reg[WIDTH-2:0], 1'b0};
          end
          count_next = count - CW'(1);
        end else begin
          quotient_next  = q_reg;
          remainder_next = r_reg;
          done_next      = 1'b1;
          state_next     = IDLE;
`ifdef DIV_ZERO_DETECT_EN
          dz_next        = zero_reg;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      zero_reg  <= 1'b0;
      dz_reg    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
      count     <= count_next;
      quotient  <= quotient_next;
      remainder <= remainder_next;
      done      <= done_next;
`ifdef DIV_ZERO_DETECT_EN
      zero_reg  <= zero_next;
      dz_reg    <= dz_next;
`endif
    end
  end

  assign busy = (state == RUN);

`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider; expected results are queued at
// start and popped by an independent monitor whenever done pulses.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    int q;
    int r;
    int dz;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for idle, raises start for one edge and queues the expected response.
  task automatic apply_stimulus(input int a, input int b, input int eq, input int er);
    exp_t e;
    int   guard = 0;
    int   zero_fast = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      check_output("start_wait_timeout", 1, 0);
      return;
    end
`ifdef DIV_ZERO_DETECT_EN
    zero_fast = (b == 0) ? 1 : 0;
`endif
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dz  = zero_fast;
    e.due = cyc + 1 + (zero_fast ? 1 : W + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check_output("quotient", int'(quotient), e.q);
        check_output("remainder", int'(remainder), e.r);
        check_output("div_by_zero", int'(div_by_zero), e.dz);
        check_output("done_cycle", cyc, e.due);
        check_output("busy_with_done", int'(busy), 0);
      end
    end
  end

  initial begin
    int n;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    #12;
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_quotient", int'(quotient), 0);
    check_output("reset_remainder", int'(remainder), 0);
    check_output("reset_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 13 / 4 with busy duration check
    apply_stimulus(13, 4, 3, 1);
    n = 0;
    for (int i = 0; i < W + 1; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check_output("busy_cycles", n, W + 1);
    check_output("busy_after_done", int'(busy), 0);

    // back-to-back: second start lands in the done cycle
    apply_stimulus(15, 1, 15, 0);
    apply_stimulus(3, 7, 0, 3);

    // zero divisor, then a normal division clears the flag
    apply_stimulus(9, 0, 15, 9);
    apply_stimulus(8, 2, 4, 0);

    // start pulses with changed operands while busy are ignored
    apply_stimulus(13, 4, 3, 1);
    @(negedge clk);
    dividend = '0;
    divisor  = '0;
    start    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;

    // reset mid-RUN discards the division
    apply_stimulus(10, 3, 3, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_output("midrun_busy", int'(busy), 0);
    check_output("midrun_done", int'(done), 0);
    check_output("midrun_quotient", int'(quotient), 0);
    check_output("midrun_remainder", int'(remainder), 0);
    check_output("midrun_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check_output("no_done_after_reset", n, 0);
    apply_stimulus(10, 3, 3, 1);

    // full operand sweep against the / and % reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) apply_stimulus(a, b, 15, a);
        else        apply_stimulus(a, b, a / b, a % b);
      end
    end

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
